// File: rtl/envia_resposta_pkg.sv
// Shared definitions for the serial response transmitter: state codes,
// frame constants and the request payload latched on acceptance.
package envia_resposta_pkg;

    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned DB_W      = 4;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned TICK_W    = 12;
    localparam int unsigned BIT_W     = 4;
    localparam int unsigned FRAME_LEN = 5;

    localparam logic [BYTE_W-1:0] HEADER_DEF     = 8'h23;
    localparam logic [BYTE_W-1:0] TERMINATOR_DEF = 8'h0A;
    localparam logic [DB_W-1:0]   DB_ILEGAL      = 4'hF;

    // State codes double as the dbEstado debug encoding.
    typedef enum logic [DB_W-1:0] {
        INICIAL   = 4'h0,
        ESPERA    = 4'h1,
        CARREGA   = 4'h2,
        TRANSMITE = 4'h3,
        PROXIMO   = 4'h4,
        FIM       = 4'h5
    } estado_t;

    // Request payload captured from the datapath.
    typedef struct packed {
        logic [BYTE_W-1:0] codigo;
        logic [BYTE_W-1:0] peso;
    } pedido_t;

    // Debug view of the state register; anything outside the legal set reads 1111.
    function automatic logic [DB_W-1:0] db_decode(input estado_t e);
        logic [DB_W-1:0] r;
        case (e)
            INICIAL, ESPERA, CARREGA, TRANSMITE, PROXIMO, FIM: r = DB_W'(e);
            default:                                           r = DB_ILEGAL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/envia_resposta_tx_serial_8n1.sv
// 8N1 byte serializer, LSB first; pronto pulses during the last stop-bit cycle.
module tx_serial_8n1
    import envia_resposta_pkg::*;
#(
    parameter int unsigned BIT_TICKS = 434
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              partida,
    input  logic [BYTE_W-1:0] dado,
    output logic              saida,
    output logic              pronto
);

    localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(BIT_TICKS - 1);
    localparam logic [TICK_W-1:0] TICK_PRE  = TICK_W'(BIT_TICKS - 2);
    localparam logic [BIT_W-1:0]  BIT_STOP  = BIT_W'(9);
    localparam logic [BIT_W-1:0]  BIT_DATA8 = BIT_W'(8);

    logic              ativo_q;
    logic [TICK_W-1:0] tick_q;
    logic [BIT_W-1:0]  bit_q;
    logic [BYTE_W-1:0] shift_q;
    logic              saida_q;
    logic              pronto_q;

    // Bit timing, shifting and line drive; the line idles high and starts are ignored mid-byte.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ativo_q  <= 1'b0;
            tick_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            saida_q  <= 1'b1;
            pronto_q <= 1'b0;
        end else if (!ativo_q) begin
            pronto_q <= 1'b0;
            if (partida) begin
                ativo_q <= 1'b1;
                tick_q  <= '0;
                bit_q   <= '0;
                shift_q <= dado;
                saida_q <= 1'b0;
            end
        end else begin
            // Registered one cycle early so it lines up with the final stop-bit tick.
            pronto_q <= (bit_q == BIT_STOP) && (tick_q == TICK_PRE);
            if (tick_q == TICK_MAX) begin
                tick_q <= '0;
                if (bit_q == BIT_STOP) begin
                    ativo_q <= 1'b0;
                    bit_q   <= '0;
                    saida_q <= 1'b1;
                end else begin
                    bit_q <= bit_q + BIT_W'(1);
                    if (bit_q < BIT_DATA8) begin
                        saida_q <= shift_q[0];
                        shift_q <= {1'b0, shift_q[BYTE_W-1:1]};
                    end else begin
                        saida_q <= 1'b1;
                    end
                end
            end else begin
                tick_q <= tick_q + TICK_W'(1);
            end
        end
    end

    assign saida  = saida_q;
    assign pronto = pronto_q;

endmodule

// File: rtl/envia_resposta.sv
// Response transmitter: on request, sends HEADER, codigo, peso, checksum, TERMINATOR over UART.
module envia_resposta
    import envia_resposta_pkg::*;
#(
    parameter int unsigned       BIT_TICKS  = 434,
    parameter logic [BYTE_W-1:0] HEADER     = HEADER_DEF,
    parameter logic [BYTE_W-1:0] TERMINATOR = TERMINATOR_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enviar,
    input  logic [BYTE_W-1:0] codigo,
    input  logic [BYTE_W-1:0] peso,
    output logic              saida_serial,
    output logic              ocupado,
    output logic              fimTransmissao,
    output logic [DB_W-1:0]   dbEstado
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

    estado_t           estado_q;
    logic [IDX_W-1:0]  idx_q;
    pedido_t           pedido_q;
    logic              partida_q;
    logic              ocupado_q;
    logic              fim_q;
    logic [BYTE_W-1:0] byte_sel;
    logic              pronto;

    // Frame byte for the current index; unreachable indices fall back to the header.
    always_comb begin
        byte_sel = HEADER;
        case (idx_q)
            3'd0:    byte_sel = HEADER;
            3'd1:    byte_sel = pedido_q.codigo;
            3'd2:    byte_sel = pedido_q.peso;
            3'd3:    byte_sel = pedido_q.codigo ^ pedido_q.peso;
            3'd4:    byte_sel = TERMINATOR;
            default: byte_sel = HEADER;
        endcase
    end

    // Frame sequencing FSM with registered start strobe, busy flag and end pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q  <= INICIAL;
            idx_q     <= '0;
            pedido_q  <= '0;
            partida_q <= 1'b0;
            ocupado_q <= 1'b0;
            fim_q     <= 1'b0;
        end else begin
            partida_q <= 1'b0;
            fim_q     <= 1'b0;
            case (estado_q)
                INICIAL: begin
                    estado_q  <= ESPERA;
                    ocupado_q <= 1'b0;
                end
                ESPERA: begin
                    if (enviar) begin
                        estado_q  <= CARREGA;
                        pedido_q  <= '{codigo: codigo, peso: peso};
                        partida_q <= 1'b1;
                        ocupado_q <= 1'b1;
                    end
                end
                CARREGA: begin
                    estado_q <= TRANSMITE;
                end
                TRANSMITE: begin
                    if (pronto) begin
                        if (idx_q == IDX_LAST) begin
                            estado_q <= FIM;
                            fim_q    <= 1'b1;
                        end else begin
                            estado_q <= PROXIMO;
                        end
                    end
                end
                PROXIMO: begin
                    idx_q     <= idx_q + IDX_W'(1);
                    estado_q  <= CARREGA;
                    partida_q <= 1'b1;
                end
                FIM: begin
                    idx_q     <= '0;
                    estado_q  <= ESPERA;
                    ocupado_q <= 1'b0;
                end
                default: begin
                    idx_q     <= '0;
                    estado_q  <= INICIAL;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    tx_serial_8n1 #(
        .BIT_TICKS(BIT_TICKS)
    ) u_tx (
        .clock  (clock),
        .reset  (reset),
        .partida(partida_q),
        .dado   (byte_sel),
        .saida  (saida_serial),
        .pronto (pronto)
    );

    assign ocupado        = ocupado_q;
    assign fimTransmissao = fim_q;
    assign dbEstado       = db_decode(estado_q);

endmodule
